// File: rtl/panel_input_conditioner_if.sv
// Front-panel signal bundle: raw buttons/switches in,
// conditioned strobes, CPU reset level and switch bus out.
interface panel_input_conditioner_if #(
    parameter int SW_W = 10
);
    logic            Run;
    logic            Continue;
    logic [SW_W-1:0] SW;
    logic            Run_pulse;
    logic            Continue_pulse;
    logic            Cpu_reset;
    logic [SW_W-1:0] SW_sync;

    // Board/top-level side: drives raw inputs, consumes conditioned outputs
    modport master (
        output Run,
        output Continue,
        output SW,
        input  Run_pulse,
        input  Continue_pulse,
        input  Cpu_reset,
        input  SW_sync
    );

    // Conditioner side
    modport slave (
        input  Run,
        input  Continue,
        input  SW,
        output Run_pulse,
        output Continue_pulse,
        output Cpu_reset,
        output SW_sync
    );
endinterface

// File: rtl/panel_input_conditioner.sv
// Front-panel input conditioner: synchronizes and debounces the
// Run/Continue buttons, decodes press events and the reset combo.
module panel_input_conditioner #(
    parameter int SYNC_STAGES     = 2,
    parameter int DEBOUNCE_CYCLES = 1,
    parameter int CNT_W           = 20,
    parameter int SW_W            = 10
) (
    input  logic                      Clk,
    input  logic                      Reset,
    panel_input_conditioner_if.slave  pif
);

    typedef enum logic [2:0] {
        IDLE,
        RUN_HELD,
        CONT_HELD,
        COMBO,
        RELEASE_WAIT
    } state_e;

    localparam logic [CNT_W-1:0] DB_LIM = CNT_W'(DEBOUNCE_CYCLES);
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    // Synchronizer chains; index 0 samples the raw pin
    logic [SYNC_STAGES-1:0]           run_sync_q, run_sync_d;
    logic [SYNC_STAGES-1:0]           cont_sync_q, cont_sync_d;
    logic [SYNC_STAGES-1:0][SW_W-1:0] sw_sync_q, sw_sync_d;

    // Debounce state; bit/slot 0 = Run, 1 = Continue (1 = released)
    logic [1:0]            lvl_q, lvl_d;
    logic [1:0][CNT_W-1:0] cnt_q, cnt_d;
    logic [1:0]            sample;

    // Combo FSM and its registered outputs
    state_e state_q, state_d;
    logic   run_pulse_q, run_pulse_d;
    logic   cont_pulse_q, cont_pulse_d;
    logic   cpu_reset_q, cpu_reset_d;

    logic rd;
    logic cd;

    // Shift each raw input one stage deeper per clock
    always_comb begin
        run_sync_d  = {run_sync_q[SYNC_STAGES-2:0], pif.Run};
        cont_sync_d = {cont_sync_q[SYNC_STAGES-2:0], pif.Continue};
        sw_sync_d   = sw_sync_q;
        sw_sync_d[0] = pif.SW;
        for (int i = 1; i < SYNC_STAGES; i++) begin
            sw_sync_d[i] = sw_sync_q[i-1];
        end
    end

    // Debounce: count consecutive disagreeing samples, flip on limit
    always_comb begin
        logic [CNT_W-1:0] inc;
        sample = {cont_sync_q[SYNC_STAGES-1], run_sync_q[SYNC_STAGES-1]};
        lvl_d  = lvl_q;
        cnt_d  = cnt_q;
        inc    = '0;
        for (int b = 0; b < 2; b++) begin
            if (sample[b] != lvl_q[b]) begin
                inc = (cnt_q[b] == CNT_MAX) ? cnt_q[b] : cnt_q[b] + 1'b1;
                if (inc >= DB_LIM) begin
                    lvl_d[b] = sample[b];
                    cnt_d[b] = '0;
                end else begin
                    cnt_d[b] = inc;
                end
            end else begin
                cnt_d[b] = '0;
            end
        end
    end

    assign rd = ~lvl_q[0];
    assign cd = ~lvl_q[1];

    // Press decoder: pulses only on the IDLE exit, reset level in COMBO
    always_comb begin
        state_d      = state_q;
        run_pulse_d  = 1'b0;
        cont_pulse_d = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (rd && cd) begin
                    state_d = COMBO;
                end else if (rd) begin
                    state_d     = RUN_HELD;
                    run_pulse_d = 1'b1;
                end else if (cd) begin
                    state_d      = CONT_HELD;
                    cont_pulse_d = 1'b1;
                end
            end
            RUN_HELD: begin
                if (cd) begin
                    state_d = COMBO;
                end else if (!rd) begin
                    state_d = IDLE;
                end
            end
            CONT_HELD: begin
                if (rd) begin
                    state_d = COMBO;
                end else if (!cd) begin
                    state_d = IDLE;
                end
            end
            COMBO: begin
                if (!rd || !cd) begin
                    state_d = RELEASE_WAIT;
                end
            end
            RELEASE_WAIT: begin
                if (rd && cd) begin
                    state_d = COMBO;
                end else if (!rd && !cd) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
        cpu_reset_d = (state_d == COMBO);
    end

    // State registers with synchronous active-low reset
    always_ff @(posedge Clk) begin
        if (!Reset) begin
            run_sync_q   <= '1;
            cont_sync_q  <= '1;
            sw_sync_q    <= '0;
            lvl_q        <= 2'b11;
            cnt_q        <= '0;
            state_q      <= IDLE;
            run_pulse_q  <= 1'b0;
            cont_pulse_q <= 1'b0;
            cpu_reset_q  <= 1'b0;
        end else begin
            run_sync_q   <= run_sync_d;
            cont_sync_q  <= cont_sync_d;
            sw_sync_q    <= sw_sync_d;
            lvl_q        <= lvl_d;
            cnt_q        <= cnt_d;
            state_q      <= state_d;
            run_pulse_q  <= run_pulse_d;
            cont_pulse_q <= cont_pulse_d;
            cpu_reset_q  <= cpu_reset_d;
        end
    end

    assign pif.Run_pulse      = run_pulse_q;
    assign pif.Continue_pulse = cont_pulse_q;
    assign pif.Cpu_reset      = cpu_reset_q;
    assign pif.SW_sync        = sw_sync_q[SYNC_STAGES-1];

endmodule

// File: tb/tb_panel_input_conditioner.sv
// Scoreboard bench: stimulus queues expected output events,
// a negedge monitor pops and compares whatever the DUTs present.
module tb_panel_input_conditioner;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   cyc = 0;
    int   n_cmp = 0;
    int   n_err = 0;
    bit   mon_en = 1'b0;

    typedef struct {
        int         cyc;
        logic [2:0] kind;
    } ev_t;

    typedef struct {
        int         cyc;
        logic [9:0] val;
    } sw_t;

    ev_t        evq[2][$];
    sw_t        swq[$];
    logic [9:0] prev_sw;
    logic [2:0] oa, ob;
    int         s;

    panel_input_conditioner_if #(.SW_W(10)) ifa ();
    panel_input_conditioner_if #(.SW_W(10)) ifb ();

    panel_input_conditioner #(
        .SYNC_STAGES(2), .DEBOUNCE_CYCLES(1), .CNT_W(20), .SW_W(10)
    ) dut_a (
        .Clk(clk), .Reset(rst_n), .pif(ifa)
    );

    panel_input_conditioner #(
        .SYNC_STAGES(2), .DEBOUNCE_CYCLES(8), .CNT_W(20), .SW_W(10)
    ) dut_b (
        .Clk(clk), .Reset(rst_n), .pif(ifb)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic void chk_out(int d, logic [2:0] o, int now);
        ev_t e;
        n_cmp++;
        if (evq[d].size() == 0) begin
            n_err++;
            $display("FAIL dut%0d_event: got {rst,cont,run}=%b at cycle %0d, required none",
                     d, o, now);
        end else begin
            e = evq[d].pop_front();
            if (e.cyc != now || e.kind !== o) begin
                n_err++;
                $display("FAIL dut%0d_event: got %b at cycle %0d, required %b at cycle %0d",
                         d, o, now, e.kind, e.cyc);
            end
        end
    endfunction

    function automatic void chk_bit(string name, logic got, logic exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %b, required %b", name, got, exp);
        end
    endfunction

    // Monitor: any asserted output or SW_sync change must match the queue head
    always @(negedge clk) begin
        if (mon_en) begin
            oa = {ifa.Cpu_reset, ifa.Continue_pulse, ifa.Run_pulse};
            ob = {ifb.Cpu_reset, ifb.Continue_pulse, ifb.Run_pulse};
            if (oa !== 3'b000) chk_out(0, oa, cyc);
            if (ob !== 3'b000) chk_out(1, ob, cyc);
            if (ifa.SW_sync !== prev_sw) begin
                n_cmp++;
                if (swq.size() == 0) begin
                    n_err++;
                    $display("FAIL sw_sync: got %h at cycle %0d, required no change",
                             ifa.SW_sync, cyc);
                end else begin
                    sw_t e;
                    e = swq.pop_front();
                    if (e.cyc != cyc || e.val !== ifa.SW_sync) begin
                        n_err++;
                        $display("FAIL sw_sync: got %h at cycle %0d, required %h at cycle %0d",
                                 ifa.SW_sync, cyc, e.val, e.cyc);
                    end
                end
                prev_sw = ifa.SW_sync;
            end
        end
    end

    task automatic step(int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic push(int d, int c, logic [2:0] k);
        ev_t e;
        e.cyc  = c;
        e.kind = k;
        evq[d].push_back(e);
    endtask

    task automatic push_sw(int c, logic [9:0] v);
        sw_t e;
        e.cyc = c;
        e.val = v;
        swq.push_back(e);
    endtask

    initial begin
        #50000;
        $display("FAIL watchdog: got timeout at cycle %0d, required completion", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        ifa.Run = 1'b1;
        ifa.Continue = 1'b1;
        ifa.SW = 10'h3FF;
        ifb.Run = 1'b1;
        ifb.Continue = 1'b1;
        ifb.SW = 10'h000;
        step(3);

        // Outputs held at zero while reset is low
        chk_bit("rst_run_pulse", ifa.Run_pulse, 1'b0);
        chk_bit("rst_cont_pulse", ifa.Continue_pulse, 1'b0);
        chk_bit("rst_cpu_reset", ifa.Cpu_reset, 1'b0);
        chk_bit("rst_sw_sync_or", |ifa.SW_sync, 1'b0);
        chk_bit("rst_b_run_pulse", ifb.Run_pulse, 1'b0);

        // Release reset; switches appear two edges later
        push_sw(cyc + 2, 10'h3FF);
        prev_sw = 10'h000;
        mon_en = 1'b1;
        rst_n = 1'b1;
        step(6);

        // One-cycle combo: a single Cpu_reset cycle, no pulses
        push(0, cyc + 4, 3'b100);
        ifa.Run = 1'b0;
        ifa.Continue = 1'b0;
        step(1);
        ifa.Run = 1'b1;
        ifa.Continue = 1'b1;
        step(5);

        // Short Run press
        push(0, cyc + 4, 3'b001);
        ifa.Run = 1'b0;
        step(1);
        ifa.Run = 1'b1;
        step(8);

        // Long Run hold: exactly one pulse
        push(0, cyc + 4, 3'b001);
        ifa.Run = 1'b0;
        step(20);
        ifa.Run = 1'b1;
        step(8);

        // Switch changes alongside a Continue press
        push_sw(cyc + 2, 10'h05A);
        push(0, cyc + 4, 3'b010);
        ifa.SW = 10'h05A;
        ifa.Continue = 1'b0;
        step(1);
        push_sw(cyc + 2, 10'h002);
        ifa.SW = 10'h002;
        ifa.Continue = 1'b1;
        step(8);

        // Run held, Continue joins, Continue leaves, then Run leaves
        s = cyc;
        push(0, s + 4, 3'b001);
        ifa.Run = 1'b0;
        step(8);
        for (int i = 0; i < 5; i++) push(0, s + 12 + i, 3'b100);
        ifa.Continue = 1'b0;
        step(5);
        ifa.Continue = 1'b1;
        step(7);
        ifa.Run = 1'b1;
        step(8);

        // Fresh press after returning to idle
        push(0, cyc + 4, 3'b001);
        ifa.Run = 1'b0;
        step(1);
        ifa.Run = 1'b1;
        step(8);

        // Long debounce: 5-cycle glitch ignored, 12-cycle press accepted
        ifb.Run = 1'b0;
        step(5);
        ifb.Run = 1'b1;
        step(15);
        push(1, cyc + 11, 3'b001);
        ifb.Run = 1'b0;
        step(12);
        ifb.Run = 1'b1;
        step(20);

        // Every expected event must have been observed
        n_cmp++;
        if (evq[0].size() != 0) begin
            n_err++;
            $display("FAIL dut0_missing: got %0d events left, required 0", evq[0].size());
        end
        n_cmp++;
        if (evq[1].size() != 0) begin
            n_err++;
            $display("FAIL dut1_missing: got %0d events left, required 0", evq[1].size());
        end
        n_cmp++;
        if (swq.size() != 0) begin
            n_err++;
            $display("FAIL sw_missing: got %0d changes left, required 0", swq.size());
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/panel_input_conditioner.md
Name: panel_input_conditioner

Overview:
Front-panel input stage sitting directly upstream of the SLC-3 CPU/datapath inside the top level. It takes raw asynchronous active-low Run and Continue buttons and the 10 switches. It synchronizes and debounces them and decodes press events. Outputs are single-cycle Run/Continue strobes, a CPU reset level for the Run+Continue combo, and a synchronized switch bus for the I/O mapped switch register.

Parameters:
SYNC_STAGES, 2, flip-flop depth of each synchronizer chain (legal 2..4)
DEBOUNCE_CYCLES, 1, consecutive differing synchronized samples required before a debounced button level flips (1 for simulation; top-level overrides for board, e.g. 500000)
CNT_W, 20, debounce counter width; must hold DEBOUNCE_CYCLES
SW_W, 10, switch bus width

Ports:
Clk  in  1  system clock, 50 MHz
Reset  in  1  synchronous, active-low block reset
Run  in  1  raw Run button, active-low (0 = pressed), asynchronous
Continue  in  1  raw Continue button, active-low, asynchronous
SW  in  SW_W  raw switches, asynchronous
Run_pulse  out  1  one-cycle high strobe on a qualified Run press
Continue_pulse  out  1  one-cycle high strobe on a qualified Continue press
Cpu_reset  out  1  active-high level; high while the Run+Continue combo is held
SW_sync  out  SW_W  synchronized switch value

Behaviour:
- Reset (sampled low at a rising Clk):
  - all synchronizer stages for Run/Continue load 1 (released); debounced levels load 1; debounce counters load 0
  - SW synchronizer stages load 0; FSM goes to IDLE; Run_pulse = Continue_pulse = Cpu_reset = 0; SW_sync = 0
  - reset mid-press clears everything; a button still held after reset release is seen as a fresh press once debounced
- Synchronizers: SYNC_STAGES-deep FF chain per signal. SW is synchronized only, not debounced. SW_sync follows SW after SYNC_STAGES edges.
- Debounce, per button, on the last sync stage:
  - if the sample differs from the debounced level, the counter increments
  - if it matches, the counter clears to 0
  - when the counter reaches DEBOUNCE_CYCLES, the debounced level takes the sample and the counter clears
  - the counter saturates and never wraps
- Latency: first rising edge sampling a raw press to the pulse being high = SYNC_STAGES + DEBOUNCE_CYCLES + 1 edges (4 with defaults). Cpu_reset assertion has the same latency.
- Combo FSM, evaluated on debounced levels (rd = Run down, cd = Continue down); outputs are registered and decoded from next-state/transition:
  - IDLE:
    - rd & !cd -> RUN_HELD, Run_pulse = 1 for one cycle
    - cd & !rd -> CONT_HELD, Continue_pulse = 1 for one cycle
    - rd & cd in the same cycle -> COMBO, no pulses
  - RUN_HELD: cd -> COMBO; !rd -> IDLE. No further Run pulses while held.
  - CONT_HELD: rd -> COMBO; !cd -> IDLE.
  - COMBO: Cpu_reset = 1 every cycle in this state; leaving either button -> RELEASE_WAIT.
  - RELEASE_WAIT: no pulses, Cpu_reset = 0; !rd & !cd -> IDLE; rd & cd again -> COMBO.
- Pulses are never high in consecutive cycles. Run_pulse and Continue_pulse are never high together. Neither pulse is ever high while Cpu_reset is high.
- A pulse already emitted before a combo forms (RUN_HELD -> COMBO) is not retracted.
- Glitch shorter than DEBOUNCE_CYCLES synchronized cycles: no level change, no pulse.

Test Plan:
- Reset low 1 cycle; Run = Continue = 1, SW = 10'h3FF -> all outputs 0 during reset; SW_sync = 10'h3FF exactly 2 edges after reset release; no pulses.
- Run and Continue driven low for 1 cycle then high (defaults) -> Cpu_reset high for exactly 1 cycle, 4 edges after the press; Run_pulse/Continue_pulse stay 0; FSM returns to IDLE.
- Run low 1 cycle, 2 cycles after the combo completes -> exactly one Run_pulse at press+4 edges; then Run held low 20 cycles -> no second pulse.
- SW = 10'h5A, then Continue low 1 cycle -> single Continue_pulse; SW change to 10'h2 shows on SW_sync 2 edges later regardless of button state.
- DEBOUNCE_CYCLES = 8: Run low for 5 cycles then high -> no pulse; Run low 12 cycles -> one pulse at press + 2 + 8 + 1 edges.
- Run held (RUN_HELD), then Continue pressed -> Cpu_reset rises; release Continue only -> RELEASE_WAIT, no Run_pulse; release Run -> IDLE; next Run press yields a pulse.
